// File: rtl/rgb_to_raw_frame_ctrl.sv
// -----------------------------------------------------------------------------
// rgb_to_raw_frame_ctrl
//
// Frame-synchronous controller for the RGB/YUV-to-RAW repacking datapath.
// - Accepts configuration requests (transfer mode and Bayer start phase) over a
//   valid/ready handshake.
// - Commits a request only on a VS rising edge. If VS never arrives, a watchdog
//   forces the commit.
// - After a mode change, mutes the datapath for C_MUTE_FRAMES frames.
// - Generates the per-line Bayer row/column phase.
// - Measures the active width and height of each frame.
//
// Ports:
//   clk, rst             video clock, synchronous active-high reset
//   vs_i, hs_i, de_i     input video timing
//   cfg_valid/cfg_ready  request handshake
//   cfg_mode, cfg_phase  requested mode and Bayer start phase
//   transfer_mode        committed mode driven to the repacker
//   row_odd, col_swap    Bayer row selector and even/odd pixel colour swap
//   mute                 datapath must blank its output
//   cfg_done             one-cycle pulse when a request is committed
//   cfg_timeout          one-cycle pulse when the VS watchdog expired
//   frame_cnt            VS rising edges since reset (saturating)
//   meas_width/height    active width/height of the previous frame
//   meas_valid           meas_* hold a completed frame measurement
// -----------------------------------------------------------------------------
module rgb_to_raw_frame_ctrl #(
   parameter int         C_CNT_W       = 16,
   parameter int         C_VS_TIMEOUT  = 2**24,
   parameter int         C_MUTE_FRAMES = 1,
   parameter logic [1:0] C_INIT_MODE   = 2'd0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vs_i,
   input  logic               hs_i,
   input  logic               de_i,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [1:0]         cfg_mode,
   input  logic [1:0]         cfg_phase,
   output logic [1:0]         transfer_mode,
   output logic               row_odd,
   output logic               col_swap,
   output logic               mute,
   output logic               cfg_done,
   output logic               cfg_timeout,
   output logic [C_CNT_W-1:0] frame_cnt,
   output logic [C_CNT_W-1:0] meas_width,
   output logic [C_CNT_W-1:0] meas_height,
   output logic               meas_valid
);

   localparam int                 C_TO_W      = $clog2(C_VS_TIMEOUT) + 1;
   localparam logic [C_TO_W-1:0]  C_TO_LAST   = C_TO_W'(C_VS_TIMEOUT - 1);
   localparam int                 C_MC_W      = $clog2(C_MUTE_FRAMES + 1) + 1;
   localparam logic [C_MC_W-1:0]  C_MUTE_INIT = C_MC_W'(C_MUTE_FRAMES);
   localparam logic [C_CNT_W-1:0] C_SAT       = '1;

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_APPLY, S_SETTLE} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_vs_d, r_hs_d, r_de_d;
   logic [1:0]          r_pend_mode, r_pend_phase, r_phase, r_transfer_mode;
   logic                r_timed_out, r_mute, r_cfg_done, r_cfg_timeout;
   logic [C_TO_W-1:0]   r_to_cnt;
   logic [C_MC_W-1:0]   r_mute_cnt;
   logic                r_has_de, r_line_odd, r_row_odd, r_col_swap;
   logic [C_CNT_W-1:0]  r_cur_w, r_last_w, r_lines, r_frame_cnt;
   logic [C_CNT_W-1:0]  r_meas_width, r_meas_height;
   logic                r_meas_valid;

   logic w_vs_pos, w_hs_pos, w_de_neg, w_to_hit, w_mute_last, w_mode_change;

   assign w_vs_pos      = vs_i & ~r_vs_d;
   assign w_hs_pos      = hs_i & ~r_hs_d;
   assign w_de_neg      = r_de_d & ~de_i;
   assign w_to_hit      = (r_to_cnt == C_TO_LAST);
   assign w_mute_last   = (r_mute_cnt == C_MC_W'(1));
   assign w_mode_change = (r_pend_mode != r_transfer_mode) && (C_MUTE_FRAMES > 0);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // NOTE: every signal assigned in a combinational block gets a default first.
   // A path that leaves it unassigned would infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (cfg_valid)             w_state_nxt = S_PEND;
         S_PEND:   if (w_vs_pos || w_to_hit)  w_state_nxt = S_APPLY;
         S_APPLY:  w_state_nxt = w_mode_change ? S_SETTLE : S_IDLE;
         S_SETTLE: if ((w_vs_pos && w_mute_last) || (!w_vs_pos && w_to_hit))
                      w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Commit path: pending request, watchdog, mute window, done/timeout pulses.
   // NOTE: sequential state is written with non-blocking assignments, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_mode     <= '0;
         r_pend_phase    <= '0;
         r_phase         <= '0;
         r_transfer_mode <= C_INIT_MODE;
         r_timed_out     <= 1'b0;
         r_to_cnt        <= '0;
         r_mute_cnt      <= '0;
         r_mute          <= 1'b0;
         r_cfg_done      <= 1'b0;
         r_cfg_timeout   <= 1'b0;
      end else begin
         r_cfg_done    <= 1'b0;
         r_cfg_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cfg_valid) begin
                  r_pend_mode  <= cfg_mode;
                  r_pend_phase <= cfg_phase;
                  r_to_cnt     <= '0;
                  r_timed_out  <= 1'b0;
               end
            end
            S_PEND: begin
               // VS wins over a watchdog expiry in the same cycle
               if (!w_vs_pos) begin
                  if (w_to_hit) r_timed_out <= 1'b1;
                  else          r_to_cnt    <= r_to_cnt + 1'b1;
               end
            end
            S_APPLY: begin
               r_transfer_mode <= r_pend_mode;
               r_phase         <= r_pend_phase;
               r_cfg_done      <= 1'b1;
               r_cfg_timeout   <= r_timed_out;
               r_to_cnt        <= '0;
               if (w_mode_change) begin
                  r_mute     <= 1'b1;
                  r_mute_cnt <= C_MUTE_INIT;
               end
            end
            S_SETTLE: begin
               if (w_vs_pos) begin
                  // The watchdog counts a missing VS, so every VS restarts it
                  r_to_cnt   <= '0;
                  r_mute_cnt <= r_mute_cnt - 1'b1;
                  if (w_mute_last) r_mute <= 1'b0;
               end else if (w_to_hit) begin
                  r_mute        <= 1'b0;
                  r_mute_cnt    <= '0;
                  r_cfg_timeout <= 1'b1;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Edge history, line phase and frame measurement
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vs_d        <= 1'b0;
         r_hs_d        <= 1'b0;
         r_de_d        <= 1'b0;
         r_has_de      <= 1'b0;
         r_line_odd    <= 1'b0;
         r_row_odd     <= 1'b0;
         r_col_swap    <= 1'b0;
         r_cur_w       <= '0;
         r_last_w      <= '0;
         r_lines       <= '0;
         r_frame_cnt   <= '0;
         r_meas_width  <= '0;
         r_meas_height <= '0;
         r_meas_valid  <= 1'b0;
      end else begin
         r_vs_d     <= vs_i;
         r_hs_d     <= hs_i;
         r_de_d     <= de_i;
         r_row_odd  <= r_line_odd ^ r_phase[1];
         r_col_swap <= r_phase[0];
         if (w_vs_pos) begin
            // VS overrides any coincident HS/DE edge and starts a clean frame
            r_has_de      <= 1'b0;
            r_line_odd    <= 1'b0;
            r_cur_w       <= '0;
            r_lines       <= '0;
            r_meas_width  <= r_last_w;
            r_meas_height <= r_lines;
            r_meas_valid  <= (r_lines != '0);
            if (r_frame_cnt != C_SAT) r_frame_cnt <= r_frame_cnt + 1'b1;
         end else begin
            if (de_i) r_has_de <= 1'b1;
            // Only lines after the first active line of the frame advance the row
            if (w_hs_pos && r_has_de) r_line_odd <= ~r_line_odd;
            if (w_hs_pos)                    r_cur_w <= '0;
            else if (de_i && r_cur_w != C_SAT) r_cur_w <= r_cur_w + 1'b1;
            // On a DE falling edge, cur_w already counts the final DE cycle
            if (w_de_neg) begin
               r_last_w <= r_cur_w;
               if (r_lines != C_SAT) r_lines <= r_lines + 1'b1;
            end
         end
      end
   end

   assign cfg_ready     = (r_state == S_IDLE);
   assign transfer_mode = r_transfer_mode;
   assign row_odd       = r_row_odd;
   assign col_swap      = r_col_swap;
   assign mute          = r_mute;
   assign cfg_done      = r_cfg_done;
   assign cfg_timeout   = r_cfg_timeout;
   assign frame_cnt     = r_frame_cnt;
   assign meas_width    = r_meas_width;
   assign meas_height   = r_meas_height;
   assign meas_valid    = r_meas_valid;

endmodule

// File: tb/tb_rgb_to_raw_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rgb_to_raw_frame_ctrl
//
// Self-checking bench for rgb_to_raw_frame_ctrl.
// - Expected commits and frame measurements are pushed to queues when the
//   stimulus is driven.
// - They are popped and compared when the DUT pulses cfg_done or advances
//   frame_cnt.
// - The DUT uses a short VS watchdog (400 cycles), so the timeout paths are
//   reachable in a short run.
// -----------------------------------------------------------------------------
module tb_rgb_to_raw_frame_ctrl;

   localparam int CW = 16;
   localparam int TO = 400;

   typedef struct {
      logic [1:0] mode;
      logic       to;
   } cfg_exp_t;

   typedef struct {
      logic [CW-1:0] w;
      logic [CW-1:0] h;
      logic          v;
      logic [CW-1:0] f;
   } meas_exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          vs_i, hs_i, de_i;
   logic          cfg_valid, cfg_ready;
   logic [1:0]    cfg_mode, cfg_phase, transfer_mode;
   logic          row_odd, col_swap, mute, cfg_done, cfg_timeout;
   logic [CW-1:0] frame_cnt, meas_width, meas_height;
   logic          meas_valid;

   int            n_tests = 0;
   int            n_fail  = 0;
   cfg_exp_t      q_cfg[$];
   meas_exp_t     q_meas[$];
   logic          armed = 1'b0;
   logic [CW-1:0] prev_fcnt = '0;
   int            m_lines = 0;
   int            m_w = 0;
   int            m_fidx = 0;
   logic [1:0]    vs_mode_snap;

   rgb_to_raw_frame_ctrl #(
      .C_CNT_W      (CW),
      .C_VS_TIMEOUT (TO),
      .C_MUTE_FRAMES(1),
      .C_INIT_MODE  (2'd0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .vs_i         (vs_i),
      .hs_i         (hs_i),
      .de_i         (de_i),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_mode     (cfg_mode),
      .cfg_phase    (cfg_phase),
      .transfer_mode(transfer_mode),
      .row_odd      (row_odd),
      .col_swap     (col_swap),
      .mute         (mute),
      .cfg_done     (cfg_done),
      .cfg_timeout  (cfg_timeout),
      .frame_cnt    (frame_cnt),
      .meas_width   (meas_width),
      .meas_height  (meas_height),
      .meas_valid   (meas_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // Advance one clock and sample just after the edge.
   // Commits and frame ends are scored here.
   task automatic tick();
      cfg_exp_t  ce;
      meas_exp_t me;
      @(posedge clk);
      #1;
      if (rst) begin
         prev_fcnt = frame_cnt;
      end else begin
         if (cfg_done === 1'b1) begin
            n_tests++;
            if (!armed || q_cfg.size() == 0) begin
               n_fail++;
               $display("FAIL commit_unexpected: cfg_done=1 mode=%0d, no commit due", transfer_mode);
            end else begin
               ce = q_cfg.pop_front();
               armed = 1'b0;
               if (transfer_mode !== ce.mode || cfg_timeout !== ce.to) begin
                  n_fail++;
                  $display("FAIL commit: mode=%0d timeout=%b, expected mode=%0d timeout=%b",
                           transfer_mode, cfg_timeout, ce.mode, ce.to);
               end
            end
         end
         if (frame_cnt !== prev_fcnt) begin
            prev_fcnt = frame_cnt;
            n_tests++;
            if (q_meas.size() == 0) begin
               n_fail++;
               $display("FAIL meas_unexpected: frame_cnt=%0d, no frame end due", frame_cnt);
            end else begin
               me = q_meas.pop_front();
               if (meas_width !== me.w || meas_height !== me.h ||
                   meas_valid !== me.v || frame_cnt !== me.f) begin
                  n_fail++;
                  $display("FAIL meas: w=%0d h=%0d v=%b f=%0d, expected w=%0d h=%0d v=%b f=%0d",
                           meas_width, meas_height, meas_valid, frame_cnt,
                           me.w, me.h, me.v, me.f);
               end
            end
         end
      end
   endtask

   // One-cycle request; the expected commit is queued when it is accepted.
   task automatic issue_req(input logic [1:0] mode, input logic [1:0] phase,
                            input logic exp_to);
      cfg_exp_t e;
      n_tests++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL req_ready: cfg_ready=%b, expected 1", cfg_ready);
      end else begin
         e.mode = mode;
         e.to   = exp_to;
         q_cfg.push_back(e);
      end
      cfg_valid = 1'b1;
      cfg_mode  = mode;
      cfg_phase = phase;
      tick();
      cfg_valid = 1'b0;
      n_tests++;
      if (cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_drop: cfg_ready=%b, expected 0", cfg_ready);
      end
   endtask

   // A VS pulse, then n_lines lines of width DE cycles each.
   // req_line = -1 issues a request in the VS cycle; -2 means no request.
   task automatic send_frame(input int n_lines, input int width, input int req_line,
                             input logic [1:0] req_mode, input logic [1:0] req_phase,
                             input bit chk_ph, input logic [1:0] exp_ph,
                             input bit hs_with_vs);
      meas_exp_t me;
      logic      exp_row;
      m_fidx++;
      me.w = CW'(m_w);
      me.h = CW'(m_lines);
      me.v = (m_lines != 0);
      me.f = CW'(m_fidx);
      q_meas.push_back(me);
      vs_i = 1'b1;
      hs_i = hs_with_vs;
      if (req_line == -1) issue_req(req_mode, req_phase, 1'b0);
      else                tick();
      vs_mode_snap = transfer_mode;
      tick();
      vs_i = 1'b0;
      hs_i = 1'b0;
      repeat (3) tick();
      for (int k = 0; k < n_lines; k++) begin
         if (!(hs_with_vs && k == 0)) begin
            hs_i = 1'b1;
            repeat (2) tick();
            hs_i = 1'b0;
         end
         repeat (2) tick();
         if (k == req_line) issue_req(req_mode, req_phase, 1'b0);
         de_i = 1'b1;
         for (int j = 0; j < width; j++) begin
            tick();
            if (chk_ph && j == width / 2) begin
               exp_row = logic'(k % 2) ^ exp_ph[1];
               n_tests++;
               if (row_odd !== exp_row || col_swap !== exp_ph[0]) begin
                  n_fail++;
                  $display("FAIL phase line %0d: row_odd=%b col_swap=%b, expected %b %b",
                           k, row_odd, col_swap, exp_row, exp_ph[0]);
               end
            end
         end
         de_i = 1'b0;
         repeat (3) tick();
      end
      m_lines = n_lines;
      m_w     = (n_lines > 0) ? width : m_w;
   endtask

   task automatic expect_out(input string name, input logic [1:0] got_mode,
                             input logic [1:0] exp_mode, input logic got_mute,
                             input logic exp_mute);
      n_tests++;
      if (got_mode !== exp_mode || got_mute !== exp_mute) begin
         n_fail++;
         $display("FAIL %s: transfer_mode=%0d mute=%b, expected %0d %b",
                  name, got_mode, got_mute, exp_mode, exp_mute);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      vs_i = 1'b0; hs_i = 1'b0; de_i = 1'b0;
      cfg_valid = 1'b0; cfg_mode = '0; cfg_phase = '0;
      repeat (3) tick();
      n_tests++;
      if (transfer_mode !== 2'd0 || cfg_ready !== 1'b1 || mute !== 1'b0 ||
          cfg_done !== 1'b0 || cfg_timeout !== 1'b0 || frame_cnt !== '0 ||
          meas_valid !== 1'b0 || meas_width !== '0 || meas_height !== '0 ||
          row_odd !== 1'b0 || col_swap !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: mode=%0d ready=%b mute=%b done=%b to=%b fcnt=%0d mv=%b",
                  transfer_mode, cfg_ready, mute, cfg_done, cfg_timeout, frame_cnt, meas_valid);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_measure();
      for (int f = 0; f < 3; f++) send_frame(8, 16, -2, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0);
      expect_out("measure_mode", transfer_mode, 2'd0, mute, 1'b0);
      n_tests++;
      if (frame_cnt !== CW'(3)) begin
         n_fail++;
         $display("FAIL frame_cnt: got %0d, expected 3", frame_cnt);
      end
   endtask

   task automatic test_mode_change();
      send_frame(8, 16, 3, 2'd2, 2'd0, 1'b1, 2'd0, 1'b0);
      expect_out("pend_hold", transfer_mode, 2'd0, mute, 1'b0);
      armed = 1'b1;
      send_frame(8, 16, -2, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0);
      expect_out("vs_edge_old_mode", vs_mode_snap, 2'd0, 1'b0, 1'b0);
      expect_out("muted_frame", transfer_mode, 2'd2, mute, 1'b1);
      send_frame(8, 16, -2, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0);
      expect_out("unmuted", transfer_mode, 2'd2, mute, 1'b0);
   endtask

   task automatic test_phase();
      send_frame(8, 16, 3, 2'd2, 2'd3, 1'b1, 2'd0, 1'b0);
      armed = 1'b1;
      send_frame(8, 16, -2, 2'd0, 2'd0, 1'b1, 2'd3, 1'b0);
      expect_out("phase_no_mute", transfer_mode, 2'd2, mute, 1'b0);
   endtask

   task automatic test_timeout();
      int n;
      armed = 1'b1;
      issue_req(2'd1, 2'd0, 1'b1);
      n = 1;
      while (cfg_done !== 1'b1 && n < 1000) begin
         tick();
         n++;
      end
      n_tests++;
      if (n < TO - 2 || n > TO + 4) begin
         n_fail++;
         $display("FAIL timeout_latency: commit after %0d cycles, expected about %0d", n, TO);
      end
      expect_out("timeout_commit", transfer_mode, 2'd1, mute, 1'b1);
      n = 0;
      while (mute !== 1'b0 && n < 1000) begin
         tick();
         n++;
      end
      n_tests++;
      if (mute !== 1'b0 || cfg_timeout !== 1'b1 || n < TO - 2 || n > TO + 4) begin
         n_fail++;
         $display("FAIL settle_timeout: mute=%b cfg_timeout=%b after %0d cycles, expected 0 1 about %0d",
                  mute, cfg_timeout, n, TO);
      end
      tick();
      n_tests++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL settle_idle: cfg_ready=%b, expected 1", cfg_ready);
      end
   endtask

   task automatic test_vs_coincide();
      send_frame(7, 16, -2, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0);
      send_frame(8, 12, -1, 2'd2, 2'd1, 1'b1, 2'd0, 1'b1);
      expect_out("vs_req_pending", transfer_mode, 2'd1, mute, 1'b0);
      armed = 1'b1;
      send_frame(8, 16, -2, 2'd0, 2'd0, 1'b1, 2'd1, 1'b0);
      expect_out("vs_req_commit", transfer_mode, 2'd2, mute, 1'b1);
   endtask

   task automatic test_reset_settle();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      n_tests++;
      if (mute !== 1'b0 || transfer_mode !== 2'd0 || cfg_ready !== 1'b1 || frame_cnt !== '0) begin
         n_fail++;
         $display("FAIL reset_settle: mute=%b mode=%0d ready=%b fcnt=%0d, expected 0 0 1 0",
                  mute, transfer_mode, cfg_ready, frame_cnt);
      end
      m_lines = 0;
      m_w     = 0;
      m_fidx  = 0;
      send_frame(4, 5, -2, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0);
      send_frame(2, 3, -2, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0);
      send_frame(0, 1, -2, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_measure();
      test_mode_change();
      test_phase();
      test_timeout();
      test_vs_coincide();
      test_reset_settle();
      repeat (4) tick();
      n_tests++;
      if (q_cfg.size() != 0 || q_meas.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d commits and %0d frame ends still due, expected 0 0",
                  q_cfg.size(), q_meas.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
